// File: rtl/draw_cmd_sequencer.sv
// Command FIFO and issue sequencer for the draw rasteriser. END_FRAME commands
// wait for VGA blanking, pulse swap_buffer, and flip the back-buffer base address.
module draw_cmd_sequencer #(
  parameter int          COORD_WIDTH   = 16,
  parameter int          COLOUR_WIDTH  = 32,
  parameter int          DEPTH         = 8,
  parameter logic [31:0] BUFFER_A_ADDR = 32'h00000000,
  parameter logic [31:0] BUFFER_B_ADDR = 32'h0012C000,
  parameter logic [3:0]  OP_END_FRAME  = 4'hF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_opcode,
  input  logic [COORD_WIDTH-1:0]    cmd_ax,
  input  logic [COORD_WIDTH-1:0]    cmd_ay,
  input  logic [COORD_WIDTH-1:0]    cmd_bx,
  input  logic [COORD_WIDTH-1:0]    cmd_by,
  input  logic [COORD_WIDTH-1:0]    cmd_cx,
  input  logic [COORD_WIDTH-1:0]    cmd_cy,
  input  logic [COLOUR_WIDTH-1:0]   cmd_colour,
  output logic                      draw_en,
  input  logic                      draw_done,
  output logic [3:0]                opcode,
  output logic [COORD_WIDTH-1:0]    ax,
  output logic [COORD_WIDTH-1:0]    ay,
  output logic [COORD_WIDTH-1:0]    bx,
  output logic [COORD_WIDTH-1:0]    by,
  output logic [COORD_WIDTH-1:0]    cx,
  output logic [COORD_WIDTH-1:0]    cy,
  output logic [COLOUR_WIDTH-1:0]   colour,
  input  logic                      vga_blank_n,
  output logic                      swap_buffer,
  output logic [31:0]               buffer_addr,
  output logic [7:0]                frame_count,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_DONE  = 3'd2;
  localparam logic [2:0] S_WAIT_BLANK = 3'd3;
  localparam logic [2:0] S_SWAP       = 3'd4;

  typedef struct packed {
    logic [3:0]              op;
    logic [COORD_WIDTH-1:0]  ax, ay, bx, by, cx, cy;
    logic [COLOUR_WIDTH-1:0] colour;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            in_cmd, head_cmd;
  cmd_t            ops_q, ops_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [2:0]      state_q, state_d;
  logic [31:0]     buffer_addr_q, buffer_addr_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            push, pop;

  // No bypass when full: readiness depends only on the registered count.
  assign cmd_ready = (count_q < FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign in_cmd    = {cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy, cmd_colour};
  assign head_cmd  = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    ops_d         = ops_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    buffer_addr_d = buffer_addr_q;
    frame_count_d = frame_count_q;
    count_d       = count_q + CNTW'(push) - CNTW'(pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head_cmd.op == OP_END_FRAME) begin
            state_d = S_WAIT_BLANK;
          end else begin
            ops_d   = head_cmd;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE:      state_d = S_WAIT_DONE;
      S_WAIT_DONE:  if (draw_done) state_d = S_IDLE;
      S_WAIT_BLANK: if (!vga_blank_n) state_d = S_SWAP;
      S_SWAP: begin
        buffer_addr_d = (buffer_addr_q == BUFFER_A_ADDR) ? BUFFER_B_ADDR : BUFFER_A_ADDR;
        frame_count_d = frame_count_q + 8'd1;
        state_d       = S_IDLE;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= in_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ops_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      buffer_addr_q <= BUFFER_B_ADDR;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ops_q         <= ops_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      buffer_addr_q <= buffer_addr_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign draw_en     = (state_q == S_ISSUE);
  assign swap_buffer = (state_q == S_SWAP);
  assign opcode      = ops_q.op;
  assign ax          = ops_q.ax;
  assign ay          = ops_q.ay;
  assign bx          = ops_q.bx;
  assign by          = ops_q.by;
  assign cx          = ops_q.cx;
  assign cy          = ops_q.cy;
  assign colour      = ops_q.colour;
  assign buffer_addr = buffer_addr_q;
  assign frame_count = frame_count_q;
  assign fifo_count  = count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Directed bench for draw_cmd_sequencer: issue latency, END_FRAME swaps,
// FIFO full/wrap behaviour, push+pop, async reset and frame counter wrap.
module tb_draw_cmd_sequencer;

  localparam logic [31:0] ADDR_A = 32'h00000000;
  localparam logic [31:0] ADDR_B = 32'h0012C000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy;
  logic [31:0] cmd_colour;
  logic        draw_en;
  logic        draw_done;
  logic [3:0]  opcode;
  logic [15:0] ax, ay, bx, by, cx, cy;
  logic [31:0] colour;
  logic        vga_blank_n;
  logic        swap_buffer;
  logic [31:0] buffer_addr;
  logic [7:0]  frame_count;
  logic [3:0]  fifo_count;
  logic        busy;

  draw_cmd_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_ax      (cmd_ax),
    .cmd_ay      (cmd_ay),
    .cmd_bx      (cmd_bx),
    .cmd_by      (cmd_by),
    .cmd_cx      (cmd_cx),
    .cmd_cy      (cmd_cy),
    .cmd_colour  (cmd_colour),
    .draw_en     (draw_en),
    .draw_done   (draw_done),
    .opcode      (opcode),
    .ax          (ax),
    .ay          (ay),
    .bx          (bx),
    .by          (by),
    .cx          (cx),
    .cy          (cy),
    .colour      (colour),
    .vga_blank_n (vga_blank_n),
    .swap_buffer (swap_buffer),
    .buffer_addr (buffer_addr),
    .frame_count (frame_count),
    .fifo_count  (fifo_count),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  int sw_cnt   = 0;
  logic [19:0] issued [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (draw_en) begin
      en_cnt++;
      issued.push_back({opcode, ax});
    end
    if (swap_buffer) sw_cnt++;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [15:0] a_x, input logic [15:0] a_y,
                         input logic [15:0] b_x, input logic [15:0] b_y,
                         input logic [15:0] c_x, input logic [15:0] c_y, input logic [31:0] col);
    cmd_opcode = op;
    cmd_ax = a_x; cmd_ay = a_y; cmd_bx = b_x; cmd_by = b_y; cmd_cx = c_x; cmd_cy = c_y;
    cmd_colour = col;
  endtask

  // Holds cmd_valid until a handshake edge has passed (bounded).
  task automatic push_cmd(input logic [3:0] op, input logic [15:0] a_x, input logic [31:0] col);
    logic ready_seen;
    bit   done;
    done = 0;
    set_cmd(op, a_x, a_x + 16'd1, a_x + 16'd2, a_x + 16'd3, a_x + 16'd4, a_x + 16'd5, col);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      ready_seen = cmd_ready;
      tick();
      done = ready_seen;
    end
    cmd_valid = 1'b0;
    if (!done) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    #3;
  endtask

  initial begin
    int  en0, sw0;
    bit  stable;
    bit  accepted;
    reset = 1'b0; cmd_valid = 1'b0; draw_done = 1'b0; vga_blank_n = 1'b1;
    set_cmd(4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    #1;
    do_reset();
    @(posedge clock); #1;

    // Reset state
    check("rst_draw_en", draw_en, 0);
    check("rst_swap", swap_buffer, 0);
    check("rst_addr", buffer_addr, ADDR_B);
    check("rst_frames", frame_count, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_operands", {opcode, ax, ay, bx, by, cx, cy, colour} == '0, 1);

    // Triangle: handshake at E0, pop at E1, draw_en in the following cycle
    set_cmd(4'd1, 16'd100, 16'd100, 16'd150, 16'd100, 16'd100, 16'd150, 32'hFFFF0000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t1_en_after_e0", draw_en, 0);
    check("t1_count_after_e0", fifo_count, 1);
    tick();
    check("t1_draw_en", draw_en, 1);
    check("t1_op", opcode, 1);
    check("t1_a", {ax, ay}, {16'd100, 16'd100});
    check("t1_b", {bx, by}, {16'd150, 16'd100});
    check("t1_c", {cx, cy}, {16'd100, 16'd150});
    check("t1_colour", colour, 32'hFFFF0000);
    en0 = en_cnt;
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ax != 16'd100 || by != 16'd100 || cy != 16'd150 || colour != 32'hFFFF0000) stable = 0;
    end
    check("t1_stable", stable, 1);
    check("t1_no_second_en", en_cnt - en0, 0);
    check("t1_busy_waiting", busy, 1);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    check("t1_idle_busy", busy, 0);

    // Clear then END_FRAME while not blanking
    en0 = en_cnt; sw0 = sw_cnt;
    push_cmd(4'd0, 16'd7, 32'h00000007);
    push_cmd(4'hF, 16'h55, 32'h55555555);
    for (int i = 0; i < 6; i++) tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t2_one_draw", en_cnt - en0, 1);
    check("t2_no_swap_yet", sw_cnt - sw0, 0);
    check("t2_ops_kept", {opcode, ax, colour}, {4'd0, 16'd7, 32'h00000007});
    check("t2_addr_before", buffer_addr, ADDR_B);
    vga_blank_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t2_one_swap", sw_cnt - sw0, 1);
    check("t2_addr_a", buffer_addr, ADDR_A);
    check("t2_frames1", frame_count, 1);
    vga_blank_n = 1'b1;
    push_cmd(4'hF, 16'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    vga_blank_n = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vga_blank_n = 1'b1;
    check("t2_addr_b", buffer_addr, ADDR_B);
    check("t2_frames2", frame_count, 2);

    // Fill FIFO while draw_done is withheld, then drain with wrap
    issued.delete();
    for (int i = 1; i <= 8; i++) push_cmd(4'(i), 16'h1000 + 16'(i), 32'(i));
    check("t3_count7", fifo_count, 7);
    check("t3_ready_at7", cmd_ready, 1);
    push_cmd(4'd9, 16'h1009, 32'd9);
    check("t3_count8", fifo_count, 8);
    check("t3_not_ready", cmd_ready, 0);
    set_cmd(4'd10, 16'h100A, 16'h100B, 16'h100C, 16'h100D, 16'h100E, 16'h100F, 32'd10);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t3_held_count", fifo_count, 8);
    draw_done = 1'b1;
    for (int i = 0; i < 60; i++) begin
      accepted = cmd_valid && cmd_ready;
      tick();
      if (accepted) cmd_valid = 1'b0;
    end
    draw_done = 1'b0;
    check("t3_held_pushed", cmd_valid, 0);
    check("t3_issued", issued.size(), 10);
    for (int i = 0; i < 10 && i < issued.size(); i++)
      check($sformatf("t3_order%0d", i), issued[i], {4'(i + 1), 16'h1000 + 16'(i + 1)});
    check("t3_drained", {busy, fifo_count}, 0);

    // Simultaneous push and pop at count 3
    issued.delete();
    push_cmd(4'd1, 16'h2001, 32'd1);
    tick(); tick();
    push_cmd(4'd2, 16'h2002, 32'd2);
    push_cmd(4'd3, 16'h2003, 32'd3);
    push_cmd(4'd4, 16'h2004, 32'd4);
    check("t4_count3_pre", fifo_count, 3);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    push_cmd(4'd5, 16'h2005, 32'd5);
    check("t4_count3_post", fifo_count, 3);
    check("t4_oldest_popped", {draw_en, opcode, ax}, {1'b1, 4'd2, 16'h2002});
    draw_done = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    draw_done = 1'b0;
    check("t4_issued", issued.size(), 5);
    if (issued.size() == 5) check("t4_last", issued[4], {4'd5, 16'h2005});

    // Reset mid S_WAIT_DONE
    push_cmd(4'd3, 16'h3000, 32'hABCD0123);
    tick(); tick();
    push_cmd(4'd4, 16'h4000, 32'd4);
    check("t5_busy_pre", {busy, opcode}, {1'b1, 4'd3});
    #2 reset = 1'b1;
    #1;
    check("t5_rst_ops", {opcode, ax, ay, bx, by, cx, cy, colour} == '0, 1);
    check("t5_rst_fifo", {busy, fifo_count, draw_en}, 0);
    check("t5_rst_addr", buffer_addr, ADDR_B);
    check("t5_rst_frames", frame_count, 0);
    #1 reset = 1'b0;
    en0 = en_cnt;
    draw_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    draw_done = 1'b0;
    check("t5_stale_done", {busy, 32'(en_cnt - en0)}, 0);

    // Reset mid S_WAIT_BLANK after one swap
    vga_blank_n = 1'b0;
    push_cmd(4'hF, 16'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_addr_a", buffer_addr, ADDR_A);
    vga_blank_n = 1'b1;
    push_cmd(4'hF, 16'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_wait_blank", {busy, swap_buffer}, {1'b1, 1'b0});
    #2 reset = 1'b1;
    #1;
    check("t5_rst2_addr", buffer_addr, ADDR_B);
    check("t5_rst2_state", {busy, swap_buffer, fifo_count, frame_count}, 0);
    #1 reset = 1'b0;
    vga_blank_n = 1'b0;
    sw0 = sw_cnt;
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_swap", sw_cnt - sw0, 0);
    vga_blank_n = 1'b1;

    // 256 END_FRAMEs: frame_count wraps, buffer_addr back to B
    sw0 = sw_cnt;
    for (int f = 0; f < 256; f++) begin
      push_cmd(4'hF, 16'h0, 32'h0);
      tick();
      vga_blank_n = 1'b0;
      tick(); tick();
      vga_blank_n = 1'b1;
      if (f == 254) check("t6_frames255", {frame_count, buffer_addr}, {8'd255, ADDR_A});
    end
    check("t6_swaps", sw_cnt - sw0, 256);
    check("t6_frames_wrap", frame_count, 0);
    check("t6_addr_b", buffer_addr, ADDR_B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/draw_cmd_sequencer.md
Name: draw_cmd_sequencer

Overview:
- Upstream feeder for the `draw` rasteriser: buffers draw commands from a producer (CPU bridge / test FSM) in a FIFO and issues them one at a time over the `draw_en`/`draw_done` handshake.
- Handles an END_FRAME pseudo-command: waits for VGA blanking, pulses `swap_buffer` to the pixel buffer controller, and toggles the back-buffer base address fed to the SDRAM interface.

Parameters:
COORD_WIDTH, 16, width of each vertex coordinate
COLOUR_WIDTH, 32, width of colour field
DEPTH, 8, FIFO entries; power of two, >= 2
BUFFER_A_ADDR, 32'h00000000, base address of buffer A
BUFFER_B_ADDR, 32'h0012C000, base address of buffer B; back buffer after reset
OP_END_FRAME, 4'hF, opcode reserved for frame end; never forwarded to draw

Ports:
clock  input  1  system clock (sys_clk domain)
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  producer has a command
cmd_ready  output  1  FIFO can accept; high when count < DEPTH
cmd_opcode  input  4  command opcode
cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy  input  COORD_WIDTH each  vertices
cmd_colour  input  COLOUR_WIDTH  colour
draw_en  output  1  one-cycle start pulse to draw
draw_done  input  1  draw completion pulse
opcode  output  4  held operand to draw
ax, ay, bx, by, cx, cy  output  COORD_WIDTH each  held operands to draw
colour  output  COLOUR_WIDTH  held operand to draw
vga_blank_n  input  1  VGA blank, active-low (low = blanking)
swap_buffer  output  1  one-cycle swap pulse
buffer_addr  output  32  current back-buffer base address
frame_count  output  8  completed swaps, wraps 255 -> 0
fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
busy  output  1  state != S_IDLE or fifo_count != 0

Behaviour:
- Reset (async, any time, including mid-draw or mid-wait):
  - FIFO emptied; state = S_IDLE.
  - draw_en = 0, swap_buffer = 0.
  - opcode, ax..cy, colour = 0.
  - buffer_addr = BUFFER_B_ADDR; frame_count = 0; busy = 0.
- FIFO write: on a rising edge with cmd_valid && cmd_ready, push {opcode, 6 coords, colour}.
  - cmd_ready = (fifo_count < DEPTH), combinational from count.
  - There is no bypass when full: a same-cycle pop does not raise cmd_ready.
  - Simultaneous push and pop leaves the count unchanged.
- State machine:
  - S_IDLE: if FIFO is non-empty, pop the head and register all operands.
    - If opcode == OP_END_FRAME, go to S_WAIT_BLANK; operand outputs keep their previous values.
    - Otherwise, go to S_ISSUE.
  - S_ISSUE: draw_en = 1 for exactly this one cycle; go to S_WAIT_DONE.
  - S_WAIT_DONE: stay until draw_done = 1, then go to S_IDLE.
    - draw_done is sampled only in this state; pulses in any other state are ignored.
    - Operands stay stable throughout.
  - S_WAIT_BLANK: stay while vga_blank_n = 1; on vga_blank_n = 0 go to S_SWAP.
  - S_SWAP: swap_buffer = 1 for this one cycle.
    - At the end of the cycle, buffer_addr toggles (A <-> B) and frame_count increments.
    - Go to S_IDLE.
- draw_en and swap_buffer are decoded from the registered state: glitch-free, exactly one cycle each.
- Latency from an empty, idle FIFO:
  - Handshake at edge E0 -> pop at E1 -> draw_en high in the cycle after E1.
  - Back-to-back commands: draw_en is next high 2 cycles after the draw_done cycle (S_IDLE, then S_ISSUE).
- Unknown opcodes other than OP_END_FRAME are forwarded unchanged; draw defines their meaning.
- Coordinates and colour pass through unmodified; no clamping.
- Pointer arithmetic is modulo DEPTH; pointers wrap naturally.

Test Plan:
- Reset, then push triangle (op 1, A=(100,100), B=(150,100), C=(100,150), colour FFFF0000) -> draw_en high on 2nd cycle after handshake with exact operands; hold draw_done low 20 cycles -> operands stable, no second draw_en; draw_done -> S_IDLE, busy = 0.
- Push clear (op 0) then END_FRAME while vga_blank_n = 1:
  - Required: draw_en once; draw_done given; swap_buffer stays 0 until vga_blank_n = 0.
  - Then: one swap pulse, buffer_addr 0012C000 -> 00000000, frame_count = 1.
  - A second END_FRAME returns buffer_addr to 0012C000.
- Fill FIFO with 8 commands while draw_done is withheld:
  - fifo_count = 7 after the first pop, and the 8th push is accepted; cmd_ready = 0 at count 8; a push held with cmd_valid = 1 is not lost.
  - Release draw_done -> all commands issued in order; verify the wrap of rd/wr pointers.
- Simultaneous push and pop (count = 3) -> count stays 3; the popped entry is the oldest.
- Assert reset mid S_WAIT_DONE and mid S_WAIT_BLANK -> outputs immediately return to reset values, FIFO empty, buffer_addr = 0012C000; a stale draw_done after reset causes no transition.
- 256 END_FRAME commands with blanking pulses -> frame_count wraps 255 -> 0; buffer_addr ends at 0012C000 (even number of swaps).
